// File: rtl/input_shift_sequencer.sv
// rtl/input_shift_sequencer.sv - capture-window controller for the input bit shifter
//
// On an accepted start the block clears the shifter, issues SHIFT_DEPTH shift
// strobes spaced div+1 enabled cycles apart, then holds window_valid_o until
// the consumer acknowledges.
//
// Ports:
//   clk, sync_rst_n      clock, synchronous active-low reset
//   clk_en               state advances only when high
//   start_i, abort_i     window start request / cancel
//   div_i                sample period minus one, latched on accepted start
//   ack_i                consumer acknowledge of a completed window
//   shift_en_o           shift strobe to the shifter
//   clear_en_o           clear strobe to the shifter
//   busy_o               high in CLEAR and CAPTURE
//   window_valid_o       high in HOLD
//   sample_count_o       shifts issued in the current window

module input_shift_sequencer #(
    parameter  int SHIFT_DEPTH = 4,
    parameter  int DIV_WIDTH   = 8,
    localparam int CW          = $clog2(SHIFT_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 sync_rst_n,
    input  logic                 clk_en,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 ack_i,
    output logic                 shift_en_o,
    output logic                 clear_en_o,
    output logic                 busy_o,
    output logic                 window_valid_o,
    output logic [CW-1:0]        sample_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_COUNT = CW'(SHIFT_DEPTH - 1);

    state_t                state;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  prescaler;
    logic [CW-1:0]         count;

    // Abort cancels any window in progress, including a shift due this cycle.
    logic abort_hit;
    assign abort_hit = abort_i && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state     <= IDLE;
            div_q     <= '0;
            prescaler <= '0;
            count     <= '0;
        end else if (clk_en) begin
            if (abort_hit) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            div_q <= div_i;
                            state <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        prescaler <= div_q;
                        count     <= '0;
                        state     <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (prescaler != '0) begin
                            prescaler <= prescaler - 1'b1;
                        end else begin
                            // Strobe cycle: reload so the next strobe is div_q+1 enabled cycles away.
                            prescaler <= div_q;
                            count     <= count + 1'b1;
                            if (count == LAST_COUNT) begin
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (ack_i) begin
                            if (start_i) begin
                                div_q <= div_i;
                                state <= CLEAR;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Strobes are decoded from registered state so they never fire on a
    // disabled cycle or on the cycle an abort lands.
    assign shift_en_o     = (state == CAPTURE) && (prescaler == '0) && clk_en && !abort_i;
    assign clear_en_o     = (state == CLEAR) && clk_en && !abort_i;
    assign busy_o         = (state == CLEAR) || (state == CAPTURE);
    assign window_valid_o = (state == HOLD);
    assign sample_count_o = count;

endmodule

// File: tb/tb_input_shift_sequencer.sv
// tb/tb_input_shift_sequencer.sv - directed self-checking bench for input_shift_sequencer

module tb_input_shift_sequencer;

    localparam int NONE = 999;

    logic       clk = 1'b0;
    logic       sync_rst_n;
    logic       clk_en;
    logic       start_i;
    logic       abort_i;
    logic [7:0] div_i;
    logic       ack_i;
    logic       shift_en_o;
    logic       clear_en_o;
    logic       busy_o;
    logic       window_valid_o;
    logic [2:0] sample_count_o;

    int checks = 0;
    int errors = 0;

    input_shift_sequencer #(
        .SHIFT_DEPTH(4),
        .DIV_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .sync_rst_n    (sync_rst_n),
        .clk_en        (clk_en),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .div_i         (div_i),
        .ack_i         (ack_i),
        .shift_en_o    (shift_en_o),
        .clear_en_o    (clear_en_o),
        .busy_o        (busy_o),
        .window_valid_o(window_valid_o),
        .sample_count_o(sample_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " shift"}, 32'(shift_en_o), 0);
        check({tag, " clear"}, 32'(clear_en_o), 0);
        check({tag, " busy"},  32'(busy_o), 0);
        check({tag, " valid"}, 32'(window_valid_o), 0);
        check({tag, " count"}, 32'(sample_count_o), 0);
    endtask

    // One window starting at cycle 0. Masks give the expected per-cycle
    // output levels; the sample count follows a small model driven by the
    // expected strobes.
    task automatic run_window(
        input string       name,
        input logic [7:0]  div,
        input int          ncyc,
        input logic [63:0] en_mask,
        input logic [63:0] shift_mask,
        input logic [63:0] clear_mask,
        input logic [63:0] busy_mask,
        input logic [63:0] valid_mask,
        input int          ack_at,
        input int          restart_at,
        input logic [7:0]  restart_div,
        input int          start_pulse_at,
        input int          abort_at
    );
        int cnt;
        string tag;
        cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            clk_en  = en_mask[c];
            start_i = (c == 0) || (c == restart_at) || (c == start_pulse_at);
            ack_i   = (c == ack_at) || (c == restart_at);
            abort_i = (c == abort_at);
            div_i   = (c == 0) ? div : ((c == restart_at) ? restart_div : 8'hA5);
            @(negedge clk);
            tag = $sformatf("%s c%0d", name, c);
            check({tag, " shift"}, 32'(shift_en_o),     32'(shift_mask[c]));
            check({tag, " clear"}, 32'(clear_en_o),     32'(clear_mask[c]));
            check({tag, " busy"},  32'(busy_o),         32'(busy_mask[c]));
            check({tag, " valid"}, 32'(window_valid_o), 32'(valid_mask[c]));
            if (busy_mask[c] || valid_mask[c] || c == abort_at + 1)
                check({tag, " count"}, 32'(sample_count_o), 32'(cnt));
            if (clear_mask[c] || c == abort_at) cnt = 0;
            else if (shift_mask[c]) cnt++;
        end
    endtask

    initial begin
        sync_rst_n = 1'b0;
        clk_en     = 1'b1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        ack_i      = 1'b0;
        div_i      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        sync_rst_n = 1'b1;

        // Divider 0: clear at 1, shifts 2..5, valid 6..8, ack at 8.
        run_window("div0", 8'd0, 10, '1, 64'h3C, 64'h2, 64'h3E, 64'h1C0,
                   8, NONE, 8'd0, NONE, NONE);

        // Divider 2, clk_en low every 4th cycle: shifts at 5, 9, 13, 17.
        run_window("div2gap", 8'd2, 22, 64'h7777_7777_7777_7777, 64'h22220, 64'h2,
                   64'h3FFFE, 64'h1C0000, 20, NONE, 8'd0, NONE, NONE);

        // Abort on the cycle the third shift is due.
        run_window("abort", 8'd0, 10, '1, 64'h0C, 64'h2, 64'h1E, 64'h0,
                   NONE, NONE, 8'd0, NONE, 4);

        // Back-to-back: ack+start in HOLD at 6 with divider 1.
        run_window("b2b", 8'd0, 19, '1, 64'hAA3C, 64'h82, 64'hFFBE, 64'h30040,
                   17, 6, 8'd1, NONE, NONE);

        // Start pulsed mid-CAPTURE is ignored.
        run_window("ignstart", 8'd0, 10, '1, 64'h3C, 64'h2, 64'h3E, 64'h1C0,
                   8, NONE, 8'd0, 3, NONE);

        // Reset held 3 cycles mid-CAPTURE, then a fresh window.
        @(posedge clk);
        #1;
        start_i = 1'b1;
        div_i   = 8'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst pre busy", 32'(busy_o), 1);
        sync_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("rst mid c%0d", i));
        end
        sync_rst_n = 1'b1;
        run_window("postrst", 8'd0, 10, '1, 64'h3C, 64'h2, 64'h3E, 64'h1C0,
                   8, NONE, 8'd0, NONE, NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
